// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, controller state encoding and a
// combinational AES-128 forward cipher built from small GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as the affine map of the field inverse (x^254; 0 maps to 0).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // AES-128 encryption of one block; byte 0 of the state is bits [127:120].
    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [4];
        logic [7:0]   rcon;
        logic [127:0] blk;
        logic [127:0] rk;
        logic [7:0]   a0, a1, a2, a3;
        blk  = pt ^ key;
        rcon = 8'h01;
        for (int k = 0; k < 4; k++) w[k] = key[127-32*k -: 32];
        for (int r = 1; r <= 10; r++) begin
            w[0] = w[0] ^ {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]),
                           sbox(w[3][31:24])} ^ {rcon, 24'h000000};
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rcon = xtime(rcon);
            rk   = {w[0], w[1], w[2], w[3]};
            for (int i = 0; i < 16; i++) s[i] = sbox(blk[127-8*i -: 8]);
            for (int c = 0; c < 4; c++) begin
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            end
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c];
                    a1 = t[4*c+1];
                    a2 = t[4*c+2];
                    a3 = t[4*c+3];
                    s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                    s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i] ^ rk[127-8*i -: 8];
        end
        return blk;
    endfunction

endpackage

// File: rtl/aes_enc_top.sv
// Combinational CBC encrypt step: out = AES_key(in ^ iv).
module aes_enc_top
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] in,
    input  logic [AES_BLK_W-1:0] iv,
    input  logic [AES_BLK_W-1:0] key,
    output logic [AES_BLK_W-1:0] out
);

    assign out = aes_encrypt(in ^ iv, key);

endmodule

// File: rtl/aes_cbc_chain_ctrl.sv
// CBC chaining controller: registers operands for the multicycle AES path,
// returns ciphertext over valid/ready and feeds it back as the next IV.
module aes_cbc_chain_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned CORE_LATENCY = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AES_BLK_W-1:0] key_in,
    input  logic [AES_BLK_W-1:0] iv_in,
    input  logic                 iv_load,
    output logic                 iv_drop,
    input  logic [AES_BLK_W-1:0] pt_data,
    input  logic                 pt_last,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    output logic [AES_BLK_W-1:0] ct_data,
    output logic                 ct_last,
    output logic                 ct_valid,
    input  logic                 ct_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_cnt
);

    localparam logic [3:0] WAIT_INIT = 4'(CORE_LATENCY - 1);

    state_t               state, state_next;
    logic [AES_BLK_W-1:0] key_reg, chain_reg, pt_reg, ct_reg, core_out;
    logic                 iv_valid, last_reg;
    logic [3:0]           wcnt;
    logic                 iv_accept, pt_fire, ct_fire;

    assign iv_accept = iv_load & (state == ST_IDLE);
    // A same-cycle iv_load takes priority over a waiting plaintext block.
    assign pt_ready  = (state == ST_IDLE) & iv_valid & ~iv_load;
    assign pt_fire   = pt_valid & pt_ready;
    assign ct_valid  = (state == ST_OUT);
    assign ct_fire   = ct_valid & ct_ready;
    assign ct_data   = ct_reg;
    assign ct_last   = last_reg;
    assign busy      = (state != ST_IDLE);

    aes_enc_top u_enc (
        .in  (pt_reg),
        .iv  (chain_reg),
        .key (key_reg),
        .out (core_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (pt_fire) state_next = ST_WAIT;
            ST_WAIT: if (wcnt == 4'd0) state_next = ST_OUT;
            ST_OUT:  if (ct_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand, chaining, result and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg   <= '0;
            chain_reg <= '0;
            iv_valid  <= 1'b0;
            pt_reg    <= '0;
            last_reg  <= 1'b0;
            ct_reg    <= '0;
            wcnt      <= 4'd0;
            blk_cnt   <= '0;
            iv_drop   <= 1'b0;
        end else begin
            iv_drop <= iv_load & (state != ST_IDLE);
            if (iv_accept) begin
                key_reg   <= key_in;
                chain_reg <= iv_in;
                iv_valid  <= 1'b1;
            end
            if (pt_fire) begin
                pt_reg   <= pt_data;
                last_reg <= pt_last;
                wcnt     <= WAIT_INIT;
            end
            if (state == ST_WAIT) begin
                if (wcnt != 4'd0) wcnt   <= wcnt - 4'd1;
                else              ct_reg <= core_out;
            end
            if (ct_fire) begin
                chain_reg <= ct_reg;
                blk_cnt   <= blk_cnt + CNT_W'(1);
                if (last_reg) iv_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_cbc_chain_ctrl.sv
// Directed bench for the CBC chaining controller using SP800-38A vectors.
module tb_aes_cbc_chain_ctrl;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 4;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] CT3 = 128'h73bed6b8e3c1743b7116e69e22229516;
    localparam logic [127:0] CT4 = 128'h3ff1caa1681fac09120eca307586e1a7;
    localparam logic [127:0] ECB1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key_in, iv_in, pt_data, ct_data;
    logic          iv_load, iv_drop, pt_last, pt_valid, pt_ready;
    logic          ct_last, ct_valid, ct_ready, busy;
    logic [CW-1:0] blk_cnt;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    aes_cbc_chain_ctrl #(
        .CORE_LATENCY (LAT),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .iv_in    (iv_in),
        .iv_load  (iv_load),
        .iv_drop  (iv_drop),
        .pt_data  (pt_data),
        .pt_last  (pt_last),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .ct_data  (ct_data),
        .ct_last  (ct_last),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .busy     (busy),
        .blk_cnt  (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and registered outputs are read 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic load_iv(input logic [127:0] k, input logic [127:0] iv);
        key_in  = k;
        iv_in   = iv;
        iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
    endtask

    // Offer a block and wait (bounded) until it is taken; edge_n restarts at acceptance.
    task automatic accept(input logic [127:0] pt, input logic last);
        int n;
        n        = 0;
        pt_data  = pt;
        pt_last  = last;
        pt_valid = 1'b1;
        #1;
        while (!pt_ready && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk("pt_ready_seen", 128'(pt_ready), 128'(1'b1));
        tick();
        edge_n   = 0;
        pt_valid = 1'b0;
    endtask

    task automatic wait_ct();
        while (!ct_valid && edge_n < 40) tick();
        chk("ct_latency", 128'(edge_n), 128'(LAT));
    endtask

    task automatic handshake();
        ct_ready = 1'b1;
        tick();
        ct_ready = 1'b0;
        chk("ct_valid_after_hs", 128'(ct_valid), 128'(1'b0));
    endtask

    initial begin
        rst = 1'b1;
        key_in = '0;
        iv_in = '0;
        iv_load = 1'b0;
        pt_data = '0;
        pt_last = 1'b0;
        pt_valid = 1'b0;
        ct_ready = 1'b0;
        tick();
        tick();
        chk("rst_pt_ready", 128'(pt_ready), 128'(1'b0));
        chk("rst_ct_valid", 128'(ct_valid), 128'(1'b0));
        chk("rst_ct_last", 128'(ct_last), 128'(1'b0));
        chk("rst_iv_drop", 128'(iv_drop), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_ct_data", ct_data, 128'h0);
        chk("rst_blk_cnt", 128'(blk_cnt), 128'h0);
        rst = 1'b0;

        // No IV yet: plaintext must stall.
        pt_valid = 1'b1;
        pt_data  = PT1;
        tick();
        tick();
        chk("no_iv_pt_ready", 128'(pt_ready), 128'(1'b0));
        chk("no_iv_busy", 128'(busy), 128'(1'b0));
        pt_valid = 1'b0;

        // First block, then 20 cycles of backpressure in OUT.
        load_iv(KEY, IV1);
        accept(PT1, 1'b0);
        wait_ct();
        chk("blk1_ct", ct_data, CT1);
        chk("blk1_last", 128'(ct_last), 128'(1'b0));
        pt_valid = 1'b1;
        pt_data  = PT2;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_ct_stable", ct_data, CT1);
            chk("bp_pt_ready", 128'(pt_ready), 128'(1'b0));
        end
        chk("bp_ct_valid", 128'(ct_valid), 128'(1'b1));
        handshake();
        chk("blk1_cnt", 128'(blk_cnt), 128'd1);

        // Second (last) block with an iv_load collision during WAIT.
        accept(PT2, 1'b1);
        iv_load = 1'b1;
        key_in  = '0;
        iv_in   = '0;
        tick();
        iv_load = 1'b0;
        chk("wait_iv_drop_hi", 128'(iv_drop), 128'(1'b1));
        tick();
        chk("wait_iv_drop_lo", 128'(iv_drop), 128'(1'b0));
        wait_ct();
        chk("blk2_ct", ct_data, CT2);
        chk("blk2_last", 128'(ct_last), 128'(1'b1));
        handshake();
        chk("blk2_cnt", 128'(blk_cnt), 128'd2);
        pt_valid = 1'b1;
        pt_data  = PT3;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("after_last_pt_ready", 128'(pt_ready), 128'(1'b0));
        end
        pt_valid = 1'b0;

        // Zero IV reduces CBC to a single ECB block.
        load_iv(KEY, 128'h0);
        accept(PT1, 1'b0);
        wait_ct();
        chk("zero_iv_ct", ct_data, ECB1);
        handshake();

        // iv_load and pt_valid together in IDLE: the IV wins, the block waits.
        key_in   = KEY;
        iv_in    = IV1;
        iv_load  = 1'b1;
        pt_data  = PT1;
        pt_last  = 1'b0;
        pt_valid = 1'b1;
        #1;
        chk("collide_pt_ready", 128'(pt_ready), 128'(1'b0));
        tick();
        iv_load = 1'b0;
        chk("collide_busy", 128'(busy), 128'(1'b0));
        accept(PT1, 1'b0);
        wait_ct();
        chk("collide_new_iv_ct", ct_data, CT1);
        handshake();
        accept(PT2, 1'b0);
        wait_ct();
        chk("collide_chain_ct", ct_data, CT2);
        handshake();
        chk("pre_rst_cnt", 128'(blk_cnt), 128'd5);

        // Asynchronous reset in WAIT.
        accept(PT3, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(1'b0));
        chk("arst_ct_valid", 128'(ct_valid), 128'(1'b0));
        chk("arst_ct_data", ct_data, 128'h0);
        chk("arst_ct_last", 128'(ct_last), 128'(1'b0));
        chk("arst_blk_cnt", 128'(blk_cnt), 128'h0);
        chk("arst_iv_drop", 128'(iv_drop), 128'(1'b0));
        chk("arst_pt_ready", 128'(pt_ready), 128'(1'b0));
        tick();
        rst = 1'b0;
        pt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("post_rst_pt_ready", 128'(pt_ready), 128'(1'b0));
        end
        pt_valid = 1'b0;

        // Full four-block chain after reset, then wrap the 4-bit counter at 17 blocks.
        load_iv(KEY, IV1);
        accept(PT1, 1'b0);
        wait_ct();
        chk("chain_ct1", ct_data, CT1);
        handshake();
        accept(PT2, 1'b0);
        wait_ct();
        chk("chain_ct2", ct_data, CT2);
        handshake();
        accept(PT3, 1'b0);
        wait_ct();
        chk("chain_ct3", ct_data, CT3);
        handshake();
        accept(PT4, 1'b0);
        wait_ct();
        chk("chain_ct4", ct_data, CT4);
        handshake();
        chk("chain_cnt", 128'(blk_cnt), 128'd4);
        for (int i = 0; i < 13; i++) begin
            accept({4{32'($urandom)}}, 1'b0);
            wait_ct();
            handshake();
            if (i == 11) chk("cnt_wrap_zero", 128'(blk_cnt), 128'd0);
        end
        chk("cnt_wrap_one", 128'(blk_cnt), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
